mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 15: maximum cycles spent in MEM without dmem_ready before a fault is declared (range 1..15).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 opcode  input  11  instruction bits [31:21] from the instruction register; sampled only in DECODE.
REQ-005 zero  input  1  ALU zero flag; sampled only in EXEC for CBZ.
REQ-006 imem_ready  input  1  instruction memory has valid data this cycle.
REQ-007 dmem_ready  input  1  data memory read or write completes this cycle.
REQ-008 IFetch  output  1  instruction memory read request.
REQ-009 IRWrite  output  1  load instruction register.
REQ-010 PCWrite  output  1  update PC this cycle.
REQ-011 PCSrc  output  1  0 = PC+4, 1 = branch target; meaningful only with PCWrite.
REQ-012 Reg2Loc, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  output  1 each  datapath controls.
REQ-013 ALUOp  output  2  00 = add (address), 01 = pass/zero test (CBZ), 10 = R-type funct.
REQ-014 state  output  3  current state encoding, for debug.
REQ-015 fault  output  1  sticky error flag.
REQ-016 retired  output  16  count of completed instructions.

Function
REQ-017 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5; codes 6 and 7 go to ERR on the next edge.
REQ-018 Decoded classes: LDUR 11111000010; STUR 11111000000; ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 (all R); CBZ opcode[10:3]=10110100; any other opcode is ILLEGAL.
REQ-019 FETCH: IFetch=1 and hold while imem_ready=0; on the cycle with imem_ready=1, IRWrite=1, PCWrite=1, PCSrc=0, then go to DECODE.
REQ-020 DECODE: opcode is latched into a class register; ILLEGAL goes to ERR; all other classes go to EXEC.
REQ-021 EXEC, R class: ALUSrc=0, ALUOp=10, Reg2Loc=0; go to WB.
REQ-022 EXEC, LDUR/STUR: ALUSrc=1, ALUOp=00, Reg2Loc=1 for STUR; go to MEM.
REQ-023 EXEC, CBZ: Reg2Loc=1, ALUSrc=0, ALUOp=01, Branch=1; if zero=1 then PCWrite=1 and PCSrc=1 in the same cycle; go to FETCH; retired increments.
REQ-024 MEM: MemRead=1 (LDUR) or MemWrite=1 (STUR), ALUSrc=1, ALUOp=00; the strobe holds until dmem_ready=1; then LDUR goes to WB and STUR goes to FETCH (retired increments).
REQ-025 MEM wait counter: 4 bits, cleared on MEM entry, increments on each MEM cycle with dmem_ready=0; reaching MEM_WAIT_MAX with dmem_ready still 0 goes to ERR; dmem_ready=1 on the same cycle wins (no fault).
REQ-026 WB: RegWrite=1 for exactly one cycle; MemtoReg=1 for LDUR, 0 for R class; go to FETCH; retired increments.
REQ-027 ERR: all control outputs are 0 and fault=1; the block stays in ERR until reset.
REQ-028 Every output not explicitly asserted for a state/class is 0.
REQ-029 All outputs are decoded from state, class register, the counters and the ready/zero inputs only; opcode has no path to any output.
REQ-030 retired wraps from 0xFFFF to 0x0000 without flagging.
REQ-031 Latency: R = 4 cycles, LDUR = 5, STUR = 4, CBZ = 3, each with zero-wait memories.
REQ-032 PCWrite is asserted at most once per instruction for the PC+4 update (FETCH), plus at most one taken-branch pulse (EXEC).

Reset
REQ-033 While reset=1: state=FETCH, class=ILLEGAL, wait counter=0, retired=0, fault=0, all strobes 0 (except IFetch=1 once reset is released).
REQ-034 Reset asserted mid-MEM or mid-WB removes MemWrite and RegWrite asynchronously in the same cycle, and no partial write is signalled after release.

Verification
REQ-035 Zero-wait ADD (10001011000): expect states 0,1,2,4,0; RegWrite high only in WB with MemtoReg=0 and ALUOp=10; retired 0->1.
REQ-036 LDUR with dmem_ready low for 3 cycles: MemRead held 4 cycles in MEM, then WB with MemtoReg=1 and RegWrite=1; total 8 cycles; fault=0.
REQ-037 STUR with dmem_ready never asserted and MEM_WAIT_MAX=15: MemWrite held 15 cycles, then ERR; fault=1, all strobes 0, state held at 5 until reset.
REQ-038 CBZ taken (zero=1) then not taken (zero=0): the taken case gives PCWrite=1 and PCSrc=1 in EXEC; the not-taken case gives PCWrite=0 in EXEC; each takes 3 cycles; retired +2.
REQ-039 Opcode 00000000000 in DECODE goes to ERR on the next edge; separately, reset asserted during MEM of a STUR drops MemWrite the same cycle and the block restarts in FETCH with retired=0.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle LEGv8-subset control FSM: sequences fetch/decode/exec/mem/writeback,
// bounds data-memory waits, and counts retired instructions.
module mc_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] opcode,
    input  logic        zero,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        IFetch,
    output logic        IRWrite,
    output logic        PCWrite,
    output logic        PCSrc,
    output logic        Reg2Loc,
    output logic        ALUSrc,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        Branch,
    output logic [1:0]  ALUOp,
    output logic [2:0]  state,
    output logic        fault,
    output logic [15:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [2:0] C_ILL = 3'd0;
    localparam logic [2:0] C_R   = 3'd1;
    localparam logic [2:0] C_LD  = 3'd2;
    localparam logic [2:0] C_ST  = 3'd3;
    localparam logic [2:0] C_CBZ = 3'd4;

    // Counter value on the last tolerated stalled MEM cycle.
    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

    logic [2:0] cls, cls_dec, next_state;
    logic [3:0] wait_cnt;
    logic       retire;

    always_comb begin
        cls_dec = C_ILL;
        if (opcode[10:3] == 8'b10110100) cls_dec = C_CBZ;
        else begin
            case (opcode)
                11'b11111000010: cls_dec = C_LD;
                11'b11111000000: cls_dec = C_ST;
                11'b10001011000,
                11'b11001011000,
                11'b10001010000,
                11'b10101010000: cls_dec = C_R;
                default:         cls_dec = C_ILL;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        retire     = 1'b0;
        case (state)
            S_FETCH:  if (imem_ready) next_state = S_DECODE;
            S_DECODE: next_state = (cls_dec == C_ILL) ? S_ERR : S_EXEC;
            S_EXEC: begin
                case (cls)
                    C_R:        next_state = S_WB;
                    C_LD, C_ST: next_state = S_MEM;
                    C_CBZ: begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                    default:    next_state = S_ERR;
                endcase
            end
            S_MEM: begin
                // A ready on the final allowed cycle still completes the access.
                if (dmem_ready) begin
                    if (cls == C_LD) next_state = S_WB;
                    else begin
                        next_state = S_FETCH;
                        retire     = 1'b1;
                    end
                end else if (wait_cnt == WAIT_LAST) next_state = S_ERR;
            end
            S_WB: begin
                next_state = S_FETCH;
                retire     = 1'b1;
            end
            default:  next_state = S_ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_FETCH;
            cls      <= C_ILL;
            wait_cnt <= 4'd0;
            retired  <= 16'd0;
        end else begin
            state   <= next_state;
            retired <= retired + 16'(retire);
            if (state == S_DECODE) cls <= cls_dec;
            if (state != S_MEM) wait_cnt <= 4'd0;
            else if (!dmem_ready) wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Outputs are forced low during reset so no strobe survives an abort.
    always_comb begin
        IFetch = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; PCSrc = 1'b0;
        Reg2Loc = 1'b0; ALUSrc = 1'b0; MemtoReg = 1'b0; RegWrite = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; Branch = 1'b0; ALUOp = 2'b00;
        fault = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    IFetch  = 1'b1;
                    IRWrite = imem_ready;
                    PCWrite = imem_ready;
                end
                S_EXEC: begin
                    case (cls)
                        C_R:  ALUOp = 2'b10;
                        C_LD: ALUSrc = 1'b1;
                        C_ST: begin
                            ALUSrc  = 1'b1;
                            Reg2Loc = 1'b1;
                        end
                        C_CBZ: begin
                            Reg2Loc = 1'b1;
                            ALUOp   = 2'b01;
                            Branch  = 1'b1;
                            PCWrite = zero;
                            PCSrc   = zero;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    ALUSrc   = 1'b1;
                    MemRead  = (cls == C_LD);
                    MemWrite = (cls == C_ST);
                end
                S_WB: begin
                    RegWrite = 1'b1;
                    MemtoReg = (cls == C_LD);
                end
                S_ERR:   fault = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: cycle-by-cycle state and control-vector checks.
module tb_mc_control;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] opcode = 11'd0;
    logic        zero = 1'b0, imem_ready = 1'b1, dmem_ready = 1'b1;
    logic        IFetch, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg;
    logic        RegWrite, MemRead, MemWrite, Branch, fault;
    logic [1:0]  ALUOp;
    logic [2:0]  state;
    logic [15:0] retired;
    logic [13:0] ctl;

    int checks = 0, failures = 0;
    logic [15:0] exp_ret = 16'd0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;

    // {IFetch,IRWrite,PCWrite,PCSrc,Reg2Loc,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp,fault}
    localparam logic [13:0] K_0   = 14'b00000000000000;
    localparam logic [13:0] K_IF  = 14'b10000000000000;
    localparam logic [13:0] K_FT  = 14'b11100000000000;
    localparam logic [13:0] K_R   = 14'b00000000000100;
    localparam logic [13:0] K_WBR = 14'b00000001000000;
    localparam logic [13:0] K_EXL = 14'b00000100000000;
    localparam logic [13:0] K_EXS = 14'b00001100000000;
    localparam logic [13:0] K_MR  = 14'b00000100100000;
    localparam logic [13:0] K_MW  = 14'b00000100010000;
    localparam logic [13:0] K_WBL = 14'b00000011000000;
    localparam logic [13:0] K_CBT = 14'b00111000001010;
    localparam logic [13:0] K_CBN = 14'b00001000001010;
    localparam logic [13:0] K_ERR = 14'b00000000000001;

    assign ctl = {IFetch, IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, MemtoReg,
                  RegWrite, MemRead, MemWrite, Branch, ALUOp, fault};

    mc_control #(.MEM_WAIT_MAX(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .IFetch(IFetch), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .state(state), .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        #1;
        checks++;
        if (state !== 3'd0 || ctl !== K_0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL reset_held: state=%0d ctl=%b retired=%0d want 0/%b/0", state, ctl, retired, K_0);
        end
        reset = 1'b0;
        imem_ready = 1'b0;
        #1;
        checks++;
        if (state !== 3'd0 || ctl !== K_IF) begin
            failures++;
            $display("FAIL reset_release: state=%0d ctl=%b want 0/%b", state, ctl, K_IF);
        end
        exp_ret = 16'd0;
    endtask

    task automatic test_add;
        logic [2:0]  st [5];
        logic [13:0] ct [5];
        logic        ir [5];
        logic [10:0] op [5];
        st = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd4};
        ct = '{K_IF, K_FT, K_0, K_R, K_WBR};
        ir = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        op = '{OP_ADD, OP_ADD, OP_ADD, 11'd0, 11'd0};
        dmem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_ready = ir[i];
            opcode = op[i];
            #1;
            checks++;
            if (state !== st[i] || ctl !== ct[i] || retired !== exp_ret) begin
                failures++;
                $display("FAIL add_cyc%0d: state=%0d ctl=%b ret=%0d want %0d/%b/%0d", i, state, ctl, retired, st[i], ct[i], exp_ret);
            end
            tick();
        end
        exp_ret++;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            failures++;
            $display("FAIL add_done: state=%0d ret=%0d want 0/%0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_ldur_wait;
        logic [2:0]  st [8];
        logic [13:0] ct [8];
        logic        dr [8];
        st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
        ct = '{K_FT, K_0, K_EXL, K_MR, K_MR, K_MR, K_MR, K_WBL};
        dr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        imem_ready = 1'b1;
        opcode = OP_LDUR;
        for (int i = 0; i < 8; i++) begin
            dmem_ready = dr[i];
            #1;
            checks++;
            if (state !== st[i] || ctl !== ct[i]) begin
                failures++;
                $display("FAIL ldur_cyc%0d: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], ct[i]);
            end
            tick();
        end
        exp_ret++;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret || fault !== 1'b0) begin
            failures++;
            $display("FAIL ldur_done: state=%0d ret=%0d fault=%b want 0/%0d/0", state, retired, fault, exp_ret);
        end
    endtask

    task automatic test_cbz;
        logic [2:0]  st [6];
        logic [13:0] ct [6];
        logic        zr [6];
        st = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        ct = '{K_FT, K_0, K_CBT, K_FT, K_0, K_CBN};
        zr = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        opcode = OP_CBZ;
        for (int i = 0; i < 6; i++) begin
            zero = zr[i];
            #1;
            checks++;
            if (state !== st[i] || ctl !== ct[i]) begin
                failures++;
                $display("FAIL cbz_cyc%0d: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], ct[i]);
            end
            tick();
        end
        exp_ret = exp_ret + 16'd2;
        zero = 1'b0;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            failures++;
            $display("FAIL cbz_done: state=%0d ret=%0d want 0/%0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_reset_mid_mem;
        logic [2:0]  st [5];
        logic [13:0] ct [5];
        st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        ct = '{K_FT, K_0, K_EXS, K_MW, K_MW};
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        opcode = OP_STUR;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (state !== st[i] || ctl !== ct[i]) begin
                failures++;
                $display("FAIL rst_mem_cyc%0d: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], ct[i]);
            end
            tick();
        end
        reset = 1'b1;
        #1;
        checks++;
        if (MemWrite !== 1'b0 || ctl !== K_0 || state !== 3'd0 || retired !== 16'd0) begin
            failures++;
            $display("FAIL rst_mem_abort: state=%0d ctl=%b ret=%0d want 0/%b/0", state, ctl, retired, K_0);
        end
        tick();
        reset = 1'b0;
        dmem_ready = 1'b1;
        exp_ret = 16'd0;
        #1;
        checks++;
        if (state !== 3'd0 || ctl !== K_FT || retired !== 16'd0) begin
            failures++;
            $display("FAIL rst_mem_restart: state=%0d ctl=%b ret=%0d want 0/%b/0", state, ctl, retired, K_FT);
        end
    endtask

    task automatic test_stur_zero_wait;
        logic [2:0]  st [4];
        logic [13:0] ct [4];
        st = '{3'd0, 3'd1, 3'd2, 3'd3};
        ct = '{K_FT, K_0, K_EXS, K_MW};
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        opcode = OP_STUR;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== st[i] || ctl !== ct[i]) begin
                failures++;
                $display("FAIL stur_cyc%0d: state=%0d ctl=%b want %0d/%b", i, state, ctl, st[i], ct[i]);
            end
            tick();
        end
        exp_ret++;
        checks++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            failures++;
            $display("FAIL stur_done: state=%0d ret=%0d want 0/%0d", state, retired, exp_ret);
        end
    endtask

    task automatic test_illegal;
        logic [2:0]  st [4];
        logic [13:0] ct [4];
        st = '{3'd0, 3'd1, 3'd5, 3'd5};
        ct = '{K_FT, K_0, K_ERR, K_ERR};
        imem_ready = 1'b1;
        opcode = 11'd0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (state !== st[i] || ctl !== ct[i] || retired !== exp_ret) begin
                failures++;
                $display("FAIL illegal_cyc%0d: state=%0d ctl=%b ret=%0d want %0d/%b/%0d", i, state, ctl, retired, st[i], ct[i], exp_ret);
            end
            tick();
        end
    endtask

    task automatic test_stur_timeout;
        logic [2:0]  es;
        logic [13:0] ec;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        opcode = OP_STUR;
        for (int i = 0; i < 21; i++) begin
            if (i == 0)      begin es = 3'd0; ec = K_FT;  end
            else if (i == 1) begin es = 3'd1; ec = K_0;   end
            else if (i == 2) begin es = 3'd2; ec = K_EXS; end
            else if (i < 18) begin es = 3'd3; ec = K_MW;  end
            else             begin es = 3'd5; ec = K_ERR; end
            #1;
            checks++;
            if (state !== es || ctl !== ec) begin
                failures++;
                $display("FAIL timeout_cyc%0d: state=%0d ctl=%b want %0d/%b", i, state, ctl, es, ec);
            end
            tick();
        end
        dmem_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbz();
        test_reset_mid_mem();
        test_stur_zero_wait();
        test_illegal();
        test_reset();
        test_stur_timeout();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
